dpm_arbiter: RTL and testbench
==============================

Name: dpm_arbiter

Overview:
- Two-client arbiter and sequencer in front of dual_port_memory. It shares the single write port and the single read port between clients A and B.
- Independent round-robin arbitration per port. Read responses return with fixed 1-cycle latency, routed to the owning client.
- Same-cycle read/write collisions to the same address are resolved deterministically.
- Sits between the clients and dual_port_memory; mem_* ports connect 1:1 to the memory.

Parameters:
- DATA_WIDTH, 32, word width; must match dual_port_memory.
- ADDR_WIDTH, 8, address width; must match dual_port_memory.

Ports:
- clk  input  1  clock; all state rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- a_wr_req / b_wr_req  input  1  write request; held, with stable addr/data, until granted.
- a_wr_addr / b_wr_addr  input  ADDR_WIDTH  write address.
- a_wr_data / b_wr_data  input  DATA_WIDTH  write data.
- a_wr_gnt / b_wr_gnt  output  1  write accepted this cycle (combinational).
- a_rd_req / b_rd_req  input  1  read request; held, with stable addr, until granted.
- a_rd_addr / b_rd_addr  input  ADDR_WIDTH  read address.
- a_rd_gnt / b_rd_gnt  output  1  read accepted this cycle (combinational).
- a_rd_valid / b_rd_valid  output  1  response valid (registered).
- a_rd_data / b_rd_data  output  DATA_WIDTH  response data; valid only with rd_valid.
- mem_wr_en, mem_wr_addr, mem_wr_data  output  1/ADDR_WIDTH/DATA_WIDTH  to memory write port.
- mem_rd_en, mem_rd_addr  output  1/ADDR_WIDTH  to memory read port.
- mem_rd_data  input  DATA_WIDTH  from memory; valid 1 cycle after mem_rd_en.

Behaviour:
- Reset, asynchronous on rst_n low:
  - wr_prio and rd_prio = A.
  - rsp_pend = 0, rsp_owner = A.
  - All *_rd_valid = 0, all *_rd_data = 0.
  - While rst_n is low, all gnt and mem_*_en outputs are forced 0, regardless of req.
- Write arbitration, each cycle:
  - One requester: granted.
  - Both requesting: the side named by wr_prio is granted.
  - On any write grant, wr_prio flips to the non-granted side at the next edge. No grant leaves wr_prio unchanged.
  - mem_wr_en = |wr_gnt; mem_wr_addr/data are muxed from the granted client, else 0.
- Read arbitration: same round-robin rule using rd_prio. mem_rd_en = |rd_gnt; mem_rd_addr is muxed from the granted client.
- The two ports are independent: in one cycle, A may win write while B wins read.
- Response path:
  - On a read grant, rsp_pend <= 1 and rsp_owner <= granted client.
  - Next cycle, the owner's rd_valid = 1 and its rd_data = mem_rd_data, registered from the memory output path. Exactly one cycle per grant.
  - Back-to-back grants produce back-to-back responses, with no bubble.
- Collision (hazard), when a write and a read are both grantable in the same cycle with equal addresses:
  - The write wins.
  - The read grant is suppressed for that cycle and rd_prio is unchanged. The read is granted the following cycle (request still held) and returns the new data.
  - Reads to different addresses are never suppressed.
- Reset mid-operation: a pending response is dropped and no rd_valid is emitted after rst_n is released.
- Fairness: a continuously requesting client waits at most 1 cycle per port, plus 1 cycle per collision.

Optional Feature:
- Macro: DPM_ARB_RAW_BYPASS_EN.
- Defined:
  - A same-address collision does not stall: the read is granted in the same cycle as the write.
  - wr_data is captured into a bypass register and the response uses it instead of mem_rd_data (read latency still 1 cycle).
  - rd_prio updates normally.
- Undefined: stall behaviour as described under Behaviour; no bypass register is present.

Test Plan:
- Reset with a_wr_req=1 held: all gnt=0, mem_wr_en=0, rd_valid=0. After release, a_wr_gnt=1 in the first cycle.
- A writes 10 to addr 3; next cycle A reads addr 3 -> a_rd_gnt=1, then 1 cycle later a_rd_valid=1 with a_rd_data=10 and b_rd_valid=0.
- A and B both hold wr_req for 4 cycles (A: addr 1 data 0x11, B: addr 2 data 0x22) -> grants go A,B,A,B, and mem_wr_addr follows 1,2,1,2.
- Same cycle: A writes 0x55 to addr 7 and B reads addr 7. Without macro: b_rd_gnt=0, then 1 next cycle, and b_rd_data=0x55 two cycles after the write. With DPM_ARB_RAW_BYPASS_EN: b_rd_gnt=1 immediately and b_rd_data=0x55 on the next cycle.
- Back-to-back reads A addr 3, B addr 4, A addr 3 -> rd_valid pulses A,B,A on consecutive cycles, each with the correct data.
- rst_n deasserted 1 cycle after a read grant -> no rd_valid pulse is ever emitted for that read; rd_prio = A.

Source files
------------

// File: rtl/dpm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dpm_arbiter
// Brief    : Two-client round-robin arbiter for the write and read ports of
//            dual_port_memory, with 1-cycle read response routing and
//            deterministic same-address write/read collision handling.
//            Optional macro DPM_ARB_RAW_BYPASS_EN: collisions do not stall the
//            read; the write data is forwarded into the response instead.
// Revision : 1.0 - initial release
// ============================================================================
module dpm_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // client A
    input  logic                  a_wr_req,
    input  logic [ADDR_WIDTH-1:0] a_wr_addr,
    input  logic [DATA_WIDTH-1:0] a_wr_data,
    output logic                  a_wr_gnt,
    input  logic                  a_rd_req,
    input  logic [ADDR_WIDTH-1:0] a_rd_addr,
    output logic                  a_rd_gnt,
    output logic                  a_rd_valid,
    output logic [DATA_WIDTH-1:0] a_rd_data,
    // client B
    input  logic                  b_wr_req,
    input  logic [ADDR_WIDTH-1:0] b_wr_addr,
    input  logic [DATA_WIDTH-1:0] b_wr_data,
    output logic                  b_wr_gnt,
    input  logic                  b_rd_req,
    input  logic [ADDR_WIDTH-1:0] b_rd_addr,
    output logic                  b_rd_gnt,
    output logic                  b_rd_valid,
    output logic [DATA_WIDTH-1:0] b_rd_data,
    // memory side
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    localparam logic c_SIDE_A = 1'b0;
    localparam logic c_SIDE_B = 1'b1;

    logic                  r_wr_prio;
    logic                  r_rd_prio;
    logic                  r_rsp_pend;
    logic                  r_rsp_owner;

    logic                  w_wr_gnt_a;
    logic                  w_wr_gnt_b;
    logic                  w_wr_any;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic                  w_rd_sel_a;
    logic                  w_rd_sel_b;
    logic [ADDR_WIDTH-1:0] w_rd_sel_addr;
    logic                  w_hazard;
    logic                  w_rd_stall;
    logic                  w_rd_gnt_a;
    logic                  w_rd_gnt_b;
    logic [DATA_WIDTH-1:0] w_rsp_data;

    // Write port round-robin; grants are forced low while reset is asserted.
    always_comb begin
        w_wr_gnt_a = rst_n & a_wr_req & (~b_wr_req | (r_wr_prio == c_SIDE_A));
        w_wr_gnt_b = rst_n & b_wr_req & (~a_wr_req | (r_wr_prio == c_SIDE_B));
        w_wr_any   = w_wr_gnt_a | w_wr_gnt_b;
        w_wr_addr  = '0;
        w_wr_data  = '0;
        if (w_wr_gnt_a) begin
            w_wr_addr = a_wr_addr;
            w_wr_data = a_wr_data;
        end else if (w_wr_gnt_b) begin
            w_wr_addr = b_wr_addr;
            w_wr_data = b_wr_data;
        end
    end

    // Read port round-robin candidate, then collision check against the write.
    always_comb begin
        w_rd_sel_a    = a_rd_req & (~b_rd_req | (r_rd_prio == c_SIDE_A));
        w_rd_sel_b    = b_rd_req & (~a_rd_req | (r_rd_prio == c_SIDE_B));
        w_rd_sel_addr = w_rd_sel_a ? a_rd_addr : (w_rd_sel_b ? b_rd_addr : '0);
        // A same-address read/write pair is a read-after-write hazard.
        w_hazard      = w_wr_any & (w_rd_sel_a | w_rd_sel_b) & (w_wr_addr == w_rd_sel_addr);
`ifdef DPM_ARB_RAW_BYPASS_EN
        w_rd_stall    = 1'b0;
`else
        // Hold the read one cycle so it observes the freshly written word.
        w_rd_stall    = w_hazard;
`endif
        w_rd_gnt_a    = rst_n & w_rd_sel_a & ~w_rd_stall;
        w_rd_gnt_b    = rst_n & w_rd_sel_b & ~w_rd_stall;
    end

    assign a_wr_gnt    = w_wr_gnt_a;
    assign b_wr_gnt    = w_wr_gnt_b;
    assign a_rd_gnt    = w_rd_gnt_a;
    assign b_rd_gnt    = w_rd_gnt_b;
    assign mem_wr_en   = w_wr_any;
    assign mem_wr_addr = w_wr_addr;
    assign mem_wr_data = w_wr_data;
    assign mem_rd_en   = w_rd_gnt_a | w_rd_gnt_b;
    assign mem_rd_addr = w_rd_gnt_a ? a_rd_addr : (w_rd_gnt_b ? b_rd_addr : '0);

    // Priority flips to the losing side after every grant on that port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_prio <= c_SIDE_A;
            r_rd_prio <= c_SIDE_A;
        end else begin
            if (w_wr_gnt_a)      r_wr_prio <= c_SIDE_B;
            else if (w_wr_gnt_b) r_wr_prio <= c_SIDE_A;
            if (w_rd_gnt_a)      r_rd_prio <= c_SIDE_B;
            else if (w_rd_gnt_b) r_rd_prio <= c_SIDE_A;
        end
    end

    // Track which client owns the response arriving on the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_pend  <= 1'b0;
            r_rsp_owner <= c_SIDE_A;
        end else begin
            r_rsp_pend <= w_rd_gnt_a | w_rd_gnt_b;
            if (w_rd_gnt_a)      r_rsp_owner <= c_SIDE_A;
            else if (w_rd_gnt_b) r_rsp_owner <= c_SIDE_B;
        end
    end

`ifdef DPM_ARB_RAW_BYPASS_EN
    logic                  r_byp_sel;
    logic [DATA_WIDTH-1:0] r_byp_data;

    // Capture colliding write data; the memory would return the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byp_sel  <= 1'b0;
            r_byp_data <= '0;
        end else begin
            r_byp_sel <= w_hazard & (w_rd_gnt_a | w_rd_gnt_b);
            if (w_hazard) r_byp_data <= w_wr_data;
        end
    end

    assign w_rsp_data = r_byp_sel ? r_byp_data : mem_rd_data;
`else
    assign w_rsp_data = mem_rd_data;
`endif

    assign a_rd_valid = r_rsp_pend & (r_rsp_owner == c_SIDE_A);
    assign b_rd_valid = r_rsp_pend & (r_rsp_owner == c_SIDE_B);
    assign a_rd_data  = a_rd_valid ? w_rsp_data : '0;
    assign b_rd_data  = b_rd_valid ? w_rsp_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_dpm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dpm_arbiter
// Brief    : Directed self-checking bench for dpm_arbiter with a behavioural
//            read-first dual-port memory attached to the mem_* ports.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dpm_arbiter;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 8;

    logic                  clk;
    logic                  rst_n;
    logic                  a_wr_req, b_wr_req, a_rd_req, b_rd_req;
    logic [ADDR_WIDTH-1:0] a_wr_addr, b_wr_addr, a_rd_addr, b_rd_addr;
    logic [DATA_WIDTH-1:0] a_wr_data, b_wr_data;
    logic                  a_wr_gnt, b_wr_gnt, a_rd_gnt, b_rd_gnt;
    logic                  a_rd_valid, b_rd_valid;
    logic [DATA_WIDTH-1:0] a_rd_data, b_rd_data;
    logic                  mem_wr_en, mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_wr_addr, mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data, mem_rd_data;

    int errors = 0;
    int checks = 0;

    dpm_arbiter #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .a_wr_req(a_wr_req), .a_wr_addr(a_wr_addr), .a_wr_data(a_wr_data), .a_wr_gnt(a_wr_gnt),
        .a_rd_req(a_rd_req), .a_rd_addr(a_rd_addr), .a_rd_gnt(a_rd_gnt),
        .a_rd_valid(a_rd_valid), .a_rd_data(a_rd_data),
        .b_wr_req(b_wr_req), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data), .b_wr_gnt(b_wr_gnt),
        .b_rd_req(b_rd_req), .b_rd_addr(b_rd_addr), .b_rd_gnt(b_rd_gnt),
        .b_rd_valid(b_rd_valid), .b_rd_data(b_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: read-first, 1-cycle read latency.
    logic [DATA_WIDTH-1:0] mem_arr [0:(1<<ADDR_WIDTH)-1];
    initial begin
        for (int i = 0; i < (1 << ADDR_WIDTH); i++) mem_arr[i] = '0;
        mem_rd_data = '0;
    end
    always @(posedge clk) begin
        if (mem_wr_en) mem_arr[mem_wr_addr] <= mem_wr_data;
        if (mem_rd_en) mem_rd_data <= mem_arr[mem_rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Hand-computed round-robin tables.
    logic       wr_exp_a [0:3] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] wr_exp_ad[0:3] = '{8'd1, 8'd2, 8'd1, 8'd2};
    logic       rd_side  [0:2] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] rd_addr  [0:2] = '{8'd3, 8'd4, 8'd3};
    logic [31:0] rd_data [0:2] = '{32'd10, 32'h44, 32'd10};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        a_wr_req = 1'b1; a_wr_addr = 8'd3; a_wr_data = 32'd10;
        b_wr_req = 1'b0; b_wr_addr = '0;   b_wr_data = '0;
        a_rd_req = 1'b1; a_rd_addr = 8'd9;
        b_rd_req = 1'b0; b_rd_addr = '0;

        // Reset: requests present but everything forced idle.
        @(negedge clk);
        chk("rst_a_wr_gnt", a_wr_gnt, 0);
        chk("rst_b_wr_gnt", b_wr_gnt, 0);
        chk("rst_a_rd_gnt", a_rd_gnt, 0);
        chk("rst_mem_wr_en", mem_wr_en, 0);
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_a_rd_valid", a_rd_valid, 0);
        chk("rst_b_rd_valid", b_rd_valid, 0);
        chk("rst_a_rd_data", a_rd_data, 0);
        next_cycle();
        rst_n = 1'b1;
        a_rd_req = 1'b0;

        // First cycle after release: held write to addr 3 is granted.
        @(negedge clk);
        chk("rel_a_wr_gnt", a_wr_gnt, 1);
        chk("rel_mem_wr_en", mem_wr_en, 1);
        chk("rel_mem_wr_addr", mem_wr_addr, 3);
        chk("rel_mem_wr_data", mem_wr_data, 10);
        next_cycle();
        a_wr_req = 1'b0;
        a_rd_req = 1'b1; a_rd_addr = 8'd3;

        // Read back addr 3.
        @(negedge clk);
        chk("rd3_a_rd_gnt", a_rd_gnt, 1);
        chk("rd3_mem_rd_en", mem_rd_en, 1);
        chk("rd3_mem_rd_addr", mem_rd_addr, 3);
        next_cycle();
        a_rd_req = 1'b0;
        chk("rd3_a_rd_valid", a_rd_valid, 1);
        chk("rd3_a_rd_data", a_rd_data, 10);
        chk("rd3_b_rd_valid", b_rd_valid, 0);

        // B writes 0x44 to addr 4; write priority is B after A's grant.
        b_wr_req = 1'b1; b_wr_addr = 8'd4; b_wr_data = 32'h44;
        @(negedge clk);
        chk("b4_b_wr_gnt", b_wr_gnt, 1);
        next_cycle();
        chk("b4_a_rd_valid_low", a_rd_valid, 0);

        // Both write continuously: A,B,A,B.
        a_wr_req = 1'b1; a_wr_addr = 8'd1; a_wr_data = 32'h11;
        b_wr_req = 1'b1; b_wr_addr = 8'd2; b_wr_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rr%0d_a_wr_gnt", i), a_wr_gnt, wr_exp_a[i]);
            chk($sformatf("rr%0d_b_wr_gnt", i), b_wr_gnt, !wr_exp_a[i]);
            chk($sformatf("rr%0d_mem_wr_addr", i), mem_wr_addr, wr_exp_ad[i]);
            next_cycle();
        end
        a_wr_req = 1'b0;
        b_wr_req = 1'b0;

        // Collision: A writes 0x55 to addr 7 while B reads addr 7.
        a_wr_req = 1'b1; a_wr_addr = 8'd7; a_wr_data = 32'h55;
        b_rd_req = 1'b1; b_rd_addr = 8'd7;
        @(negedge clk);
        chk("col_a_wr_gnt", a_wr_gnt, 1);
`ifdef DPM_ARB_RAW_BYPASS_EN
        chk("col_b_rd_gnt", b_rd_gnt, 1);
        next_cycle();
        a_wr_req = 1'b0;
        b_rd_req = 1'b0;
        chk("col_b_rd_valid", b_rd_valid, 1);
        chk("col_b_rd_data", b_rd_data, 32'h55);
`else
        chk("col_b_rd_gnt_stall", b_rd_gnt, 0);
        chk("col_mem_rd_en_stall", mem_rd_en, 0);
        next_cycle();
        a_wr_req = 1'b0;
        chk("col_b_rd_valid_none", b_rd_valid, 0);
        @(negedge clk);
        chk("col_b_rd_gnt_retry", b_rd_gnt, 1);
        chk("col_mem_rd_addr", mem_rd_addr, 7);
        next_cycle();
        b_rd_req = 1'b0;
        chk("col_b_rd_valid", b_rd_valid, 1);
        chk("col_b_rd_data", b_rd_data, 32'h55);
`endif

        // Back-to-back reads A3, B4, A3; read priority is A here.
        for (int i = 0; i < 3; i++) begin
            a_rd_req = (rd_side[i] == 1'b0);
            b_rd_req = (rd_side[i] == 1'b1);
            a_rd_addr = rd_addr[i];
            b_rd_addr = rd_addr[i];
            @(negedge clk);
            chk($sformatf("b2b%0d_a_rd_gnt", i), a_rd_gnt, !rd_side[i]);
            chk($sformatf("b2b%0d_b_rd_gnt", i), b_rd_gnt, rd_side[i]);
            next_cycle();
            a_rd_req = 1'b0;
            b_rd_req = 1'b0;
            chk($sformatf("b2b%0d_a_rd_valid", i), a_rd_valid, !rd_side[i]);
            chk($sformatf("b2b%0d_b_rd_valid", i), b_rd_valid, rd_side[i]);
            chk($sformatf("b2b%0d_rd_data", i), rd_side[i] ? b_rd_data : a_rd_data, rd_data[i]);
        end

        // Reset right after a read grant: the pending response is dropped.
        a_rd_req = 1'b1; a_rd_addr = 8'd3;
        @(negedge clk);
        chk("mid_a_rd_gnt", a_rd_gnt, 1);
        next_cycle();
        a_rd_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_a_rd_valid_rst", a_rd_valid, 0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("mid%0d_a_rd_valid", i), a_rd_valid, 0);
            chk($sformatf("mid%0d_b_rd_valid", i), b_rd_valid, 0);
        end
        next_cycle();

        // Read priority back at A: both request, A wins.
        a_rd_req = 1'b1; a_rd_addr = 8'd3;
        b_rd_req = 1'b1; b_rd_addr = 8'd4;
        @(negedge clk);
        chk("prio_a_rd_gnt", a_rd_gnt, 1);
        chk("prio_b_rd_gnt", b_rd_gnt, 0);
        next_cycle();
        a_rd_req = 1'b0;
        b_rd_req = 1'b0;
        chk("prio_a_rd_valid", a_rd_valid, 1);
        chk("prio_a_rd_data", a_rd_data, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
